serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller. Adds two WIDTH-bit operands plus carry-in by

---
 rtl/serial_add_ctrl_if.sv | 32 +++
 rtl/serial_add_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_add_ctrl_if                                                |
// | Brief   : Requester-side handshake and operand/result bus for the serial    |
// |           adder controller.                                                |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, abort, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, abort, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : serial_add_ctrl                                                  |
// | Brief   : Bit-serial adder controller: one full-adder slice, one bit per   |
// |           clock, LSB first, with start/done/abort handshake.               |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic               w_x;
    logic               w_y;
    logic               w_z;
    logic               w_s;
    logic               w_c;

    // Full-adder slice (x, y, z -> s, c), fed from the operand LSBs and the carry
    assign w_x = r_a[0];
    assign w_y = r_b[0];
    assign w_z = r_carry;
    assign w_s = w_x ^ w_y ^ w_z;
    assign w_c = (w_x & w_y) | (w_z & (w_x ^ w_y));

    assign w_last = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                // An aborted cycle does not advance the datapath, freezing partial results
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sum   <= '0;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
            // On the MSB, r_carry is the carry into the MSB and w_c the carry out
            if (w_last) begin
                r_cout <= w_c;
                r_ovf  <= w_c ^ r_carry;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_serial_add_ctrl                                               |
// | Brief   : Directed and random bench for serial_add_ctrl (WIDTH = 8).       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request and return at the negedge of the done cycle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output logic [7:0] s, output logic co, output logic ov,
                          output int busy_n, output int lat);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        busy_n = 0;
        lat    = 0;
        s      = 'x;
        co     = 1'bx;
        ov     = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            if (bus.busy) busy_n++;
            if (bus.done) begin
                lat = i;
                s   = bus.sum;
                co  = bus.cout;
                ov  = bus.ovf;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL rst_sum: got %h expected 00", bus.sum); end
        n_checks++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL rst_cout: got %b expected 0", bus.cout); end
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf); end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co, ov; int bn, lat;
        run_op(8'h0F, 8'h01, 1'b0, s, co, ov, bn, lat);
        n_checks++; if (bn !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bn); end
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        n_checks++; if (s !== 8'h10) begin n_fail++; $display("FAIL basic_sum: got %h expected 10", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b expected 0", co); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", ov); end
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
    endtask

    task automatic test_carry_ovf();
        logic [7:0] s; logic co, ov; int bn, lat;
        run_op(8'hFF, 8'h01, 1'b0, s, co, ov, bn, lat);
        n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL wrap_sum: got %h expected 00", s); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL wrap_cout: got %b expected 1", co); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL wrap_ovf: got %b expected 0", ov); end
        run_op(8'h7F, 8'h00, 1'b1, s, co, ov, bn, lat);
        n_checks++; if (s !== 8'h80) begin n_fail++; $display("FAIL posovf_sum: got %h expected 80", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL posovf_cout: got %b expected 0", co); end
        n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL posovf_ovf: got %b expected 1", ov); end
    endtask

    task automatic test_neg_ovf_hold();
        logic [7:0] s; logic co, ov; int bn, lat;
        run_op(8'h80, 8'h80, 1'b0, s, co, ov, bn, lat);
        n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL negovf_sum: got %h expected 00", s); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL negovf_cout: got %b expected 1", co); end
        n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL negovf_ovf: got %b expected 1", ov); end
        bus.a = 8'h33;
        bus.b = 8'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sum !== 8'h00 || bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_result[%0d]: got %h/%b/%b expected 00/1/1", i, bus.sum, bus.cout, bus.ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_done, last_idx;
        n_done   = 0;
        last_idx = -1;
        @(negedge clk);
        bus.a     = 8'h01;
        bus.b     = 8'h02;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                n_checks++; if (bus.sum !== 8'h03) begin n_fail++; $display("FAIL b2b_sum: got %h expected 03", bus.sum); end
                n_checks++;
                if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_done: got %b expected 0", bus.busy); end
                if (last_idx >= 0) begin
                    n_checks++;
                    if (i - last_idx !== 10) begin n_fail++; $display("FAIL b2b_period: got %0d expected 10", i - last_idx); end
                end
                last_idx = i;
            end
        end
        bus.start = 1'b0;
        n_checks++; if (n_done !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", n_done); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_no_restart: got %b expected 0", bus.busy); end
    endtask

    task automatic test_abort();
        logic [7:0] s; logic co, ov; int bn, lat, n_done;
        @(negedge clk);
        bus.a     = 8'h0F;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b expected 1", bus.busy); end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        // abort still high with start: request must not be accepted
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_prio: got %b expected 0", bus.busy); end
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) n_done++;
            @(negedge clk);
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", n_done); end
        run_op(8'h55, 8'hAA, 1'b1, s, co, ov, bn, lat);
        n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL post_abort_sum: got %h expected 00", s); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL post_abort_cout: got %b expected 1", co); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL post_abort_ovf: got %b expected 0", ov); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s; logic co, ov; int bn, lat;
        @(negedge clk);
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (bus.sum === 8'h00) begin n_fail++; $display("FAIL midrun_partial: got %h expected nonzero", bus.sum); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sum !== 8'h00 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, s, co, ov, bn, lat);
        n_checks++; if (s !== 8'h46) begin n_fail++; $display("FAIL post_reset_sum: got %h expected 46", s); end
        n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL post_reset_cout: got %b expected 0", co); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, s; logic cin, co, ov, exp_ov; logic [8:0] full; int bn, lat;
        for (int k = 0; k < 1000; k++) begin
            a      = 8'($urandom_range(0, 255));
            b      = 8'($urandom_range(0, 255));
            cin    = 1'($urandom_range(0, 1));
            full   = 9'(a) + 9'(b) + 9'(cin);
            exp_ov = (a[7] == b[7]) && (full[7] != a[7]);
            run_op(a, b, cin, s, co, ov, bn, lat);
            n_checks++;
            if ({co, s} !== full || ov !== exp_ov || lat !== 9) begin
                n_fail++;
                $display("FAIL rand_op[%0d] %h+%h+%b: got %b_%h ovf=%b lat=%0d expected %b_%h ovf=%b lat=9",
                         k, a, b, cin, co, s, ov, lat, full[8], full[7:0], exp_ov);
            end
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rand_done_width[%0d]: got %b expected 0", k, bus.done); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_carry_ovf();
        test_neg_ovf_hold();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
